// File: rtl/mem_access_arbiter_if.sv
// Requester and memory-side signals of the memory access arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_access_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        d_req;
   logic        d_we;
   logic [1:0]  d_size;
   logic        d_unsigned;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        d_err;
   logic [31:0] addr;
   logic [31:0] mem_write;
   logic        wr_en;
   logic [31:0] mem_read;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_read,
      output if_rdata, if_ack, d_rdata, d_ack, d_err, addr, mem_write, wr_en
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_read,
      input  if_rdata, if_ack, d_rdata, d_ack, d_err, addr, mem_write, wr_en
   );
endinterface

// File: rtl/mem_access_arbiter.sv
// Shares one single-port data memory between fetch and load/store; sub-word stores use read-modify-write.
// Latency: fetch/load 3, word store 2, sub-word store 4, error 2 cycles; requesters hold req until ack.
module mem_access_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic clk,
   input  logic rst,
   mem_access_arbiter_if.slave bus
);
   typedef enum logic [2:0] {IDLE, F_ADDR, F_DATA, D_ADDR, D_DATA, D_WR, D_ERR} state_t;

   state_t      state_q, state_d;
   logic        last_grant_q, last_grant_d;   // 1 = data won the last grant
   logic [31:0] addr_q, addr_d;
   logic [31:0] mem_write_q, mem_write_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        wr_en_q, wr_en_d;
   logic        if_ack_q, if_ack_d;
   logic        d_ack_q, d_ack_d;
   logic        d_err_q, d_err_d;

   logic        grant_f, grant_d, misaligned;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_val, merged;

   always_comb begin
      grant_f = 1'b0;
      grant_d = 1'b0;
      if (bus.if_req && bus.d_req) begin
         grant_d = !RR_EN || !last_grant_q;
         grant_f = !grant_d;
      end else begin
         grant_f = bus.if_req;
         grant_d = bus.d_req;
      end
   end

   always_comb begin
      case (bus.d_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = bus.d_addr[0];
         2'b10:   misaligned = |bus.d_addr[1:0];
         default: misaligned = 1'b1;
      endcase
   end

   // Lane extraction for loads and lane replacement for sub-word stores.
   always_comb begin
      case (bus.d_addr[1:0])
         2'd0:    rd_byte = bus.mem_read[7:0];
         2'd1:    rd_byte = bus.mem_read[15:8];
         2'd2:    rd_byte = bus.mem_read[23:16];
         default: rd_byte = bus.mem_read[31:24];
      endcase
      rd_half = bus.d_addr[1] ? bus.mem_read[31:16] : bus.mem_read[15:0];
      case (bus.d_size)
         2'b00:   load_val = {{24{~bus.d_unsigned & rd_byte[7]}}, rd_byte};
         2'b01:   load_val = {{16{~bus.d_unsigned & rd_half[15]}}, rd_half};
         default: load_val = bus.mem_read;
      endcase
      merged = bus.mem_read;
      if (bus.d_size == 2'b00) begin
         case (bus.d_addr[1:0])
            2'd0:    merged[7:0]   = bus.d_wdata[7:0];
            2'd1:    merged[15:8]  = bus.d_wdata[7:0];
            2'd2:    merged[23:16] = bus.d_wdata[7:0];
            default: merged[31:24] = bus.d_wdata[7:0];
         endcase
      end else if (bus.d_addr[1]) begin
         merged[31:16] = bus.d_wdata[15:0];
      end else begin
         merged[15:0] = bus.d_wdata[15:0];
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      mem_write_d  = mem_write_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      wr_en_d      = 1'b0;
      if_ack_d     = 1'b0;
      d_ack_d      = 1'b0;
      d_err_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_f) begin
               last_grant_d = 1'b0;
               addr_d       = bus.if_addr & 32'hFFFF_FFFC;
               state_d      = F_ADDR;
            end else if (grant_d) begin
               last_grant_d = 1'b1;
               if (misaligned) begin
                  state_d = D_ERR;
               end else begin
                  addr_d = bus.d_addr & 32'hFFFF_FFFC;
                  if (bus.d_we && bus.d_size == 2'b10) begin
                     mem_write_d = bus.d_wdata;
                     wr_en_d     = 1'b1;
                     state_d     = D_WR;
                  end else begin
                     state_d = D_ADDR;
                  end
               end
            end
         end
         F_ADDR: state_d = F_DATA;
         F_DATA: begin
            if_rdata_d = bus.mem_read;
            if_ack_d   = 1'b1;
            state_d    = IDLE;
         end
         D_ADDR: state_d = D_DATA;
         D_DATA: begin
            if (bus.d_we) begin
               mem_write_d = merged;
               wr_en_d     = 1'b1;
               state_d     = D_WR;
            end else begin
               d_rdata_d = load_val;
               d_ack_d   = 1'b1;
               state_d   = IDLE;
            end
         end
         D_WR: begin
            d_ack_d = 1'b1;
            state_d = IDLE;
         end
         D_ERR: begin
            d_ack_d = 1'b1;
            d_err_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b0;
         addr_q       <= '0;
         mem_write_q  <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
         wr_en_q      <= 1'b0;
         if_ack_q     <= 1'b0;
         d_ack_q      <= 1'b0;
         d_err_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         mem_write_q  <= mem_write_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
         wr_en_q      <= wr_en_d;
         if_ack_q     <= if_ack_d;
         d_ack_q      <= d_ack_d;
         d_err_q      <= d_err_d;
      end
   end

   assign bus.addr      = addr_q;
   assign bus.mem_write = mem_write_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.if_ack    = if_ack_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.d_err     = d_err_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench: table of load/store vectors plus fetch, contention and reset-abort sequences.
module tb_mem_access_arbiter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_access_arbiter_if b1 ();
   mem_access_arbiter_if b0 ();

   mem_access_arbiter #(.RR_EN(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
   mem_access_arbiter #(.RR_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

   assign b0.mem_read = 32'h0;

   logic [31:0] mem [0:255];
   int          wr_cnt = 0;
   logic        pl_vld = 1'b0;
   logic [7:0]  pl_idx = '0;
   logic [31:0] pl_dat = '0;
   int          viol = 0;
   int          n_pass = 0;
   int          n_tot = 0;

   // Memory model: one-cycle read latency, write on wr_en at the edge.
   always @(posedge clk) begin
      b1.mem_read <= mem[b1.addr[9:2]];
      if (b1.wr_en) begin
         mem[b1.addr[9:2]] = b1.mem_write;
         wr_cnt++;
      end
      if (pl_vld) mem[pl_idx] = pl_dat;
   end

   always @(negedge clk) begin
      if (b1.if_ack && b1.d_ack) viol++;
      if (b0.if_ack && b0.d_ack) viol++;
      if (b1.d_err && !b1.d_ack) viol++;
      if (b0.d_err && !b0.d_ack) viol++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] idx, input logic [31:0] dat);
      pl_idx = idx;
      pl_dat = dat;
      pl_vld = 1'b1;
      step();
      pl_vld = 1'b0;
   endtask

   task automatic run_data(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd, output logic err);
      b1.d_we = we; b1.d_size = sz; b1.d_unsigned = uns; b1.d_addr = a; b1.d_wdata = wd;
      b1.d_req = 1'b1;
      lat = 0;
      do begin
         step();
         lat++;
      end while (!b1.d_ack && lat < 20);
      rd  = b1.d_rdata;
      err = b1.d_err;
      b1.d_req = 1'b0;
   endtask

   task automatic run_fetch(input logic [31:0] a, output int lat, output logic [31:0] rd);
      b1.if_addr = a;
      b1.if_req  = 1'b1;
      lat = 0;
      do begin
         step();
         lat++;
      end while (!b1.if_ack && lat < 20);
      rd = b1.if_rdata;
      b1.if_req = 1'b0;
   endtask

   function automatic logic outs_nonzero();
      return |{b1.if_rdata, b1.if_ack, b1.d_rdata, b1.d_ack, b1.d_err,
               b1.addr, b1.mem_write, b1.wr_en};
   endfunction

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] pre;
      int          lat;
      logic        err;
      logic [31:0] rdata;
      logic [31:0] mem_after;
      int          writes;
   } vec_t;

   vec_t vecs [18];

   initial begin
      int          lat, w0, n, d_cnt, f_cnt0, d_cnt0;
      int          seq [4];
      logic [31:0] rd, a_before;
      logic        err;

      vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h80F07F01, 3, 1'b0, 32'h00000001, 32'h80F07F01, 0};
      vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'h80F07F01, 3, 1'b0, 32'hFFFFFF80, 32'h80F07F01, 0};
      vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 32'h80F07F01, 3, 1'b0, 32'h00000080, 32'h80F07F01, 0};
      vecs[3]  = '{1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h80F07F01, 3, 1'b0, 32'hFFFF80F0, 32'h80F07F01, 0};
      vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h80F07F01, 3, 1'b0, 32'h000080F0, 32'h80F07F01, 0};
      vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 32'h80F07F01, 3, 1'b0, 32'h00007F01, 32'h80F07F01, 0};
      vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h80F07F01, 3, 1'b0, 32'h80F07F01, 32'h80F07F01, 0};
      vecs[7]  = '{1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'h80F07F01, 3, 1'b0, 32'h0000007F, 32'h80F07F01, 0};
      vecs[8]  = '{1'b1, 2'b00, 1'b0, 32'h41, 32'h000000AA, 32'h11223344, 4, 1'b0, 32'h0, 32'h1122AA44, 1};
      vecs[9]  = '{1'b1, 2'b01, 1'b0, 32'h42, 32'h0000BEEF, 32'h11223344, 4, 1'b0, 32'h0, 32'hBEEF3344, 1};
      vecs[10] = '{1'b1, 2'b00, 1'b0, 32'h43, 32'h000001FF, 32'h11223344, 4, 1'b0, 32'h0, 32'hFF223344, 1};
      vecs[11] = '{1'b1, 2'b10, 1'b0, 32'h44, 32'hCAFEF00D, 32'h00000000, 2, 1'b0, 32'h0, 32'hCAFEF00D, 1};
      vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h80F07F01, 2, 1'b1, 32'h0, 32'h80F07F01, 0};
      vecs[13] = '{1'b0, 2'b11, 1'b0, 32'h30, 32'h0, 32'h55555555, 2, 1'b1, 32'h0, 32'h55555555, 0};
      vecs[14] = '{1'b1, 2'b01, 1'b0, 32'h41, 32'h0000BEEF, 32'h11223344, 2, 1'b1, 32'h0, 32'h11223344, 0};
      vecs[15] = '{1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h12345678, 32'h00000000, 2, 1'b0, 32'h0, 32'h12345678, 1};
      vecs[16] = '{1'b0, 2'b00, 1'b1, 32'hFFFFFFFF, 32'h0, 32'h12345678, 3, 1'b0, 32'h00000012, 32'h12345678, 0};
      vecs[17] = '{1'b1, 2'b01, 1'b0, 32'h40, 32'hABCDBEEF, 32'h11223344, 4, 1'b0, 32'h0, 32'h1122BEEF, 1};

      rst = 1'b1;
      b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0;
      b1.d_size = 2'b00; b1.d_unsigned = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
      b0.if_req = 1'b0; b0.if_addr = '0; b0.d_req = 1'b0; b0.d_we = 1'b0;
      b0.d_size = 2'b10; b0.d_unsigned = 1'b0; b0.d_addr = '0; b0.d_wdata = '0;
      repeat (3) step();
      chk("reset_outputs", {31'b0, outs_nonzero()}, 32'h0);
      rst = 1'b0;
      step();

      // Fetch path, with and without low address bits set.
      preload(8'h04, 32'hDEADBEEF);
      w0 = wr_cnt;
      run_fetch(32'h10, lat, rd);
      chk("fetch_lat", lat, 3);
      chk("fetch_rdata", rd, 32'hDEADBEEF);
      run_fetch(32'h13, lat, rd);
      chk("fetch13_rdata", rd, 32'hDEADBEEF);
      chk("fetch_no_write", wr_cnt - w0, 0);

      for (int i = 0; i < 18; i++) begin
         preload(vecs[i].a[9:2], vecs[i].pre);
         a_before = b1.addr;
         w0 = wr_cnt;
         run_data(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].a, vecs[i].wd, lat, rd, err);
         chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
         chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].err});
         if (!vecs[i].we && !vecs[i].err) chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
         if (vecs[i].err) chk($sformatf("v%0d_addr_hold", i), b1.addr, a_before);
         chk($sformatf("v%0d_mem", i), mem[vecs[i].a[9:2]], vecs[i].mem_after);
         chk($sformatf("v%0d_writes", i), wr_cnt - w0, vecs[i].writes);
      end

      // Contention from reset: RR_EN=1 alternates starting with data, RR_EN=0 starves fetch.
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      b1.if_addr = 32'h10; b1.d_we = 1'b0; b1.d_size = 2'b10; b1.d_addr = 32'h20;
      b1.if_req = 1'b1; b1.d_req = 1'b1;
      b0.if_addr = 32'h10; b0.if_req = 1'b1; b0.d_req = 1'b1;
      for (int i = 0; i < 4; i++) seq[i] = -1;
      n = 0; f_cnt0 = 0; d_cnt0 = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (n < 4 && b1.d_ack) begin seq[n] = 1; n++; end
         else if (n < 4 && b1.if_ack) begin seq[n] = 0; n++; end
         if (b0.if_ack) f_cnt0++;
         if (b0.d_ack) d_cnt0++;
      end
      b1.if_req = 1'b0; b1.d_req = 1'b0; b0.if_req = 1'b0; b0.d_req = 1'b0;
      repeat (6) step();
      chk("rr_ack_count", n, 4);
      for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), seq[i], (i % 2 == 0) ? 1 : 0);
      chk("prio_fetch_acks", f_cnt0, 0);
      d_cnt = d_cnt0;
      chk("prio_data_acks", {31'b0, d_cnt >= 10}, 32'h1);

      // Reset in D_DATA of a byte store: no write, no ack.
      preload(8'h14, 32'h11223344);
      w0 = wr_cnt;
      b1.d_we = 1'b1; b1.d_size = 2'b00; b1.d_unsigned = 1'b0; b1.d_addr = 32'h51; b1.d_wdata = 32'hAA;
      b1.d_req = 1'b1;
      step(); step();
      rst = 1'b1; b1.d_req = 1'b0;
      step();
      chk("rst_sb_outputs", {31'b0, outs_nonzero()}, 32'h0);
      chk("rst_sb_writes", wr_cnt - w0, 0);
      chk("rst_sb_mem", mem[8'h14], 32'h11223344);
      rst = 1'b0;
      step();

      // Reset during D_WR of a word store: the presented write lands, no ack.
      preload(8'h15, 32'h0);
      w0 = wr_cnt;
      b1.d_we = 1'b1; b1.d_size = 2'b10; b1.d_addr = 32'h54; b1.d_wdata = 32'h5A5A1234;
      b1.d_req = 1'b1;
      step();
      chk("sw_wr_en", {31'b0, b1.wr_en}, 32'h1);
      rst = 1'b1; b1.d_req = 1'b0;
      step();
      chk("rst_sw_mem", mem[8'h15], 32'h5A5A1234);
      chk("rst_sw_writes", wr_cnt - w0, 1);
      chk("rst_sw_outputs", {31'b0, outs_nonzero()}, 32'h0);
      rst = 1'b0;
      step(); step();

      chk("ack_exclusive_err_qualified", viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
